// File: rtl/ps2_pkg.sv
// Shared scancodes, RX state encoding and colour helpers for the PS/2 cursor controller.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_UP  = 8'h75;
    localparam logic [7:0] SC_DN  = 8'h72;
    localparam logic [7:0] SC_LT  = 8'h6B;
    localparam logic [7:0] SC_RT  = 8'h74;
    localparam logic [7:0] SC_C   = 8'h21;
    localparam logic [7:0] SC_R   = 8'h2D;

    localparam logic [2:0] COLOR_FRAME   = 3'b100;
    localparam logic [2:0] COLOR_DEFAULT = 3'b001;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // The frame colour is reserved, so the square never takes it.
    function automatic logic [2:0] next_color(input logic [2:0] c);
        logic [2:0] n;
        n = c + 3'd1;
        return (n == COLOR_FRAME) ? n + 3'd1 : n;
    endfunction

endpackage

// File: rtl/ps2_cursor_ctrl_if.sv
// PS/2 pins, frame strobe and committed cursor outputs. Optional oParityErr under PS2_PARITY_CHECK_EN.
interface ps2_cursor_if;
    logic       iPS2Clock;
    logic       iPS2Data;
    logic       iFrameStrobe;
    logic [9:0] oXRedCounter;
    logic [9:0] oYRedCounter;
    logic [2:0] oColorCuadro;
    logic [7:0] oScanCode;
    logic       oKeyValid;
`ifdef PS2_PARITY_CHECK_EN
    logic       oParityErr;

    modport master (
        output iPS2Clock, iPS2Data, iFrameStrobe,
        input  oXRedCounter, oYRedCounter, oColorCuadro, oScanCode, oKeyValid, oParityErr
    );
    modport slave (
        input  iPS2Clock, iPS2Data, iFrameStrobe,
        output oXRedCounter, oYRedCounter, oColorCuadro, oScanCode, oKeyValid, oParityErr
    );
`else
    modport master (
        output iPS2Clock, iPS2Data, iFrameStrobe,
        input  oXRedCounter, oYRedCounter, oColorCuadro, oScanCode, oKeyValid
    );
    modport slave (
        input  iPS2Clock, iPS2Data, iFrameStrobe,
        output oXRedCounter, oYRedCounter, oColorCuadro, oScanCode, oKeyValid
    );
`endif
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM with abort timeout.
// PS2_PARITY_CHECK_EN enables odd-parity checking and the parity_err_o pulse.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int TW             = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       valid_o
`ifdef PS2_PARITY_CHECK_EN
    ,
    output logic       parity_err_o
`endif
);

    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q;
    rx_state_e     state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q, byte_q;
    logic          valid_q;
    logic [TW-1:0] tmo_q;
`ifdef PS2_PARITY_CHECK_EN
    logic          par_q, perr_q;
`endif

    logic fall, din;
    assign fall = clk_prev_q & ~clk_sync_q[1];
    assign din  = dat_sync_q[1];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_data_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            tmo_q     <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
            if (fall) begin
                tmo_q <= '0;
                case (state_q)
                    RX_IDLE: if (!din) begin
                        state_q   <= RX_DATA;
                        bit_cnt_q <= '0;
                    end
                    RX_DATA: begin
                        shift_q   <= {din, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_q <= din;
`endif
                        state_q <= RX_STOP;
                    end
                    default: begin
`ifdef PS2_PARITY_CHECK_EN
                        if (din && (^{shift_q, par_q})) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else if (din) begin
                            perr_q  <= 1'b1;
                        end
`else
                        if (din) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
`endif
                        state_q <= RX_IDLE;
                    end
                endcase
            end else if (state_q != RX_IDLE) begin
                // Saturating counter: a stuck partial frame is abandoned, never wrapped.
                if (tmo_q == TMO_MAX) state_q <= RX_IDLE;
                else                  tmo_q   <= tmo_q + 1'b1;
            end
        end
    end

    assign byte_o  = byte_q;
    assign valid_o = valid_q;
`ifdef PS2_PARITY_CHECK_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: rtl/ps2_cursor_ctrl.sv
// Keyboard-driven cursor: decodes PS/2 bytes into staged X/Y/colour, committed on the frame strobe.
// PS2_PARITY_CHECK_EN adds parity checking and the oParityErr output.
module ps2_cursor_ctrl
    import ps2_pkg::*;
#(
    parameter int         STEP           = 32,
    parameter logic [9:0] XMAX           = 10'd320,
    parameter logic [9:0] YMAX           = 10'd32,
    parameter int         TIMEOUT_CYCLES = 25000,
    parameter int         TW             = 15
) (
    input logic          Clock,
    input logic          Reset,
    ps2_cursor_if.slave  bus
);

    localparam logic [10:0] STEP11 = 11'(STEP);

    logic [7:0] rx_byte;
    logic       rx_valid;

`ifdef PS2_PARITY_CHECK_EN
    logic rx_perr;
`endif

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (TW)
    ) u_rx (
        .Clock        (Clock),
        .Reset        (Reset),
        .ps2_clk_i    (bus.iPS2Clock),
        .ps2_data_i   (bus.iPS2Data),
        .byte_o       (rx_byte),
        .valid_o      (rx_valid)
`ifdef PS2_PARITY_CHECK_EN
        ,
        .parity_err_o (rx_perr)
`endif
    );

    logic [9:0]  x_q, x_d, y_q, y_d, xo_q, yo_q;
    logic [2:0]  col_q, col_d, colo_q;
    logic        brk_q, brk_d, ext_q, ext_d;
    logic [10:0] x_add, y_add;

    assign x_add = {1'b0, x_q} + STEP11;
    assign y_add = {1'b0, y_q} + STEP11;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        col_d = col_q;
        brk_d = brk_q;
        ext_d = ext_q;
        if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                ext_d = 1'b0;
                // Arrows live on the E0 page; C and R are plain codes.
                if (ext_q) begin
                    case (rx_byte)
                        SC_UP: y_d = ({1'b0, y_q} < STEP11) ? '0 : y_q - STEP11[9:0];
                        SC_DN: y_d = (y_add > {1'b0, YMAX}) ? YMAX : y_add[9:0];
                        SC_LT: x_d = ({1'b0, x_q} < STEP11) ? '0 : x_q - STEP11[9:0];
                        SC_RT: x_d = (x_add > {1'b0, XMAX}) ? XMAX : x_add[9:0];
                        default: ;
                    endcase
                end else begin
                    case (rx_byte)
                        SC_C: col_d = next_color(col_q);
                        SC_R: begin
                            x_d   = '0;
                            y_d   = '0;
                            col_d = COLOR_DEFAULT;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            x_q    <= '0;
            y_q    <= '0;
            col_q  <= COLOR_DEFAULT;
            brk_q  <= 1'b0;
            ext_q  <= 1'b0;
            xo_q   <= '0;
            yo_q   <= '0;
            colo_q <= COLOR_DEFAULT;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            col_q <= col_d;
            brk_q <= brk_d;
            ext_q <= ext_d;
            // Commit the post-decode value so a coincident key is not lost for a frame.
            if (bus.iFrameStrobe) begin
                xo_q   <= x_d;
                yo_q   <= y_d;
                colo_q <= col_d;
            end
        end
    end

    assign bus.oXRedCounter = xo_q;
    assign bus.oYRedCounter = yo_q;
    assign bus.oColorCuadro = colo_q;
    assign bus.oScanCode    = rx_byte;
    assign bus.oKeyValid    = rx_valid;
`ifdef PS2_PARITY_CHECK_EN
    assign bus.oParityErr   = rx_perr;
`endif

endmodule

// File: tb/tb_ps2_cursor_ctrl.sv
// Scoreboard bench for ps2_cursor_ctrl: frames push expected scancodes, the key pulse monitor is drained per test.
module tb_ps2_cursor_ctrl;

    localparam int HALF = 6;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    ps2_cursor_if bus();

    ps2_cursor_ctrl dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] code;
        int         fall;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_fall = 0;
    int   rd = 0;

    // Monitor-owned observation log.
    int         kv_cnt = 0;
    logic [7:0] obs_code [256];
    int         obs_cyc  [256];
    int         perr_cnt = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (bus.oKeyValid === 1'b1) begin
            obs_code[kv_cnt % 256] = bus.oScanCode;
            obs_cyc[kv_cnt % 256]  = cyc;
            kv_cnt = kv_cnt + 1;
        end
`ifdef PS2_PARITY_CHECK_EN
        if (bus.oParityErr === 1'b1) perr_cnt = perr_cnt + 1;
`endif
    end

    task automatic ps2_bit(input logic b, input logic co);
        @(negedge Clock);
        bus.iPS2Data = b;
        repeat (HALF) @(negedge Clock);
        bus.iPS2Clock = 1'b0;
        last_fall = cyc;
        if (co) begin
            repeat (3) @(negedge Clock);
            bus.iFrameStrobe = 1'b1;
            @(negedge Clock);
            bus.iFrameStrobe = 1'b0;
            repeat (HALF - 4) @(negedge Clock);
        end else begin
            repeat (HALF) @(negedge Clock);
        end
        bus.iPS2Clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic co, input logic expect_kv);
        exp_t e;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit((~^b) ^ bad_par, 1'b0);
        ps2_bit(1'b1, co);
        if (expect_kv) begin
            e.code = b;
            e.fall = last_fall;
            exp_q.push_back(e);
        end
        @(negedge Clock);
        bus.iPS2Data = 1'b1;
    endtask

    task automatic strobe();
        @(negedge Clock);
        bus.iFrameStrobe = 1'b1;
        @(negedge Clock);
        bus.iFrameStrobe = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    // Pop every expected key and match it against the monitor log.
    task automatic sb_drain(input string name);
        int n_exp;
        exp_t e;
        repeat (20) @(negedge Clock);
        n_exp = exp_q.size();
        tests++;
        if (kv_cnt - rd !== n_exp) begin
            fails++;
            $display("FAIL %s pulse count: got %0d need %0d", name, kv_cnt - rd, n_exp);
            rd = kv_cnt;
            exp_q.delete();
        end else begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (obs_code[rd % 256] !== e.code) begin
                    fails++;
                    $display("FAIL %s scancode: got %h need %h", name, obs_code[rd % 256], e.code);
                end
                tests++;
                if (obs_cyc[rd % 256] - e.fall !== 3) begin
                    fails++;
                    $display("FAIL %s latency: got %0d need 3", name, obs_cyc[rd % 256] - e.fall);
                end
                rd++;
            end
        end
    endtask

    task automatic test_reset();
        bus.iPS2Clock = 1'b1;
        bus.iPS2Data = 1'b1;
        bus.iFrameStrobe = 1'b0;
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        tests++;
        if ({bus.oXRedCounter, bus.oYRedCounter, bus.oColorCuadro, bus.oScanCode, bus.oKeyValid} !== {10'd0, 10'd0, 3'b001, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got x=%0d y=%0d c=%b sc=%h kv=%b need 0 0 001 00 0",
                     bus.oXRedCounter, bus.oYRedCounter, bus.oColorCuadro, bus.oScanCode, bus.oKeyValid);
        end
        Reset = 1'b1;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        tests++;
        if ({bus.oXRedCounter, bus.oYRedCounter, bus.oColorCuadro, bus.oKeyValid} !== {10'd0, 10'd0, 3'b001, 1'b0}) begin
            fails++;
            $display("FAIL reset_midframe: got x=%0d y=%0d c=%b kv=%b need 0 0 001 0",
                     bus.oXRedCounter, bus.oYRedCounter, bus.oColorCuadro, bus.oKeyValid);
        end
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        sb_drain("reset_nopulse");
        send_frame(8'h21, 1'b0, 1'b0, 1'b1);
        sb_drain("reset_next_frame");
        strobe();
        tests++;
        if (bus.oColorCuadro !== 3'b010) begin
            fails++;
            $display("FAIL reset_next_color: got %b need 010", bus.oColorCuadro);
        end
    endtask

    task automatic test_right();
        do_reset();
        send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b0, 1'b1);
        sb_drain("right_keys");
        tests++;
        if (bus.oXRedCounter !== 10'd0) begin
            fails++;
            $display("FAIL right_prestrobe: got %0d need 0", bus.oXRedCounter);
        end
        strobe();
        tests++;
        if (bus.oXRedCounter !== 10'd32) begin
            fails++;
            $display("FAIL right_one: got %0d need 32", bus.oXRedCounter);
        end
        for (int i = 0; i < 10; i++) begin
            send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
            send_frame(8'h74, 1'b0, 1'b0, 1'b1);
        end
        sb_drain("right_repeat_keys");
        strobe();
        tests++;
        if (bus.oXRedCounter !== 10'd320) begin
            fails++;
            $display("FAIL right_clamp: got %0d need 320", bus.oXRedCounter);
        end
    endtask

    task automatic test_coincide();
        do_reset();
        send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1, 1'b1);
        sb_drain("coincide_keys");
        tests++;
        if (bus.oXRedCounter !== 10'd32) begin
            fails++;
            $display("FAIL coincide_commit: got %0d need 32", bus.oXRedCounter);
        end
    endtask

    task automatic test_updown();
        do_reset();
        send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b0, 1'b1);
        strobe();
        tests++;
        if (bus.oYRedCounter !== 10'd0) begin
            fails++;
            $display("FAIL up_at_zero: got %0d need 0", bus.oYRedCounter);
        end
        send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h72, 1'b0, 1'b0, 1'b1);
        sb_drain("updown_keys");
        tests++;
        if (bus.oYRedCounter !== 10'd0) begin
            fails++;
            $display("FAIL down_prestrobe: got %0d need 0", bus.oYRedCounter);
        end
        strobe();
        tests++;
        if (bus.oYRedCounter !== 10'd32) begin
            fails++;
            $display("FAIL down_one: got %0d need 32", bus.oYRedCounter);
        end
        send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h72, 1'b0, 1'b0, 1'b1);
        strobe();
        tests++;
        if ({bus.oXRedCounter, bus.oYRedCounter} !== {10'd0, 10'd32}) begin
            fails++;
            $display("FAIL down_clamp: got x=%0d y=%0d need 0 32", bus.oXRedCounter, bus.oYRedCounter);
        end
        sb_drain("updown_tail");
    endtask

    task automatic test_color();
        logic [2:0] want [3];
        want[0] = 3'b010;
        want[1] = 3'b011;
        want[2] = 3'b101;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h21, 1'b0, 1'b0, 1'b1);
            strobe();
            tests++;
            if (bus.oColorCuadro !== want[i]) begin
                fails++;
                $display("FAIL color_step%0d: got %b need %b", i, bus.oColorCuadro, want[i]);
            end
        end
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h21, 1'b0, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b0, 1'b1);
        strobe();
        tests++;
        if ({bus.oColorCuadro, bus.oXRedCounter} !== {3'b101, 10'd0}) begin
            fails++;
            $display("FAIL break_ignored: got c=%b x=%0d need 101 0", bus.oColorCuadro, bus.oXRedCounter);
        end
        sb_drain("color_keys");
    endtask

    task automatic test_timeout();
        send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h72, 1'b0, 1'b0, 1'b1);
        strobe();
        sb_drain("timeout_setup");
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        repeat (25010) @(negedge Clock);
        sb_drain("timeout_nopulse");
        send_frame(8'h2D, 1'b0, 1'b0, 1'b1);
        sb_drain("timeout_next_frame");
        tests++;
        if ({bus.oXRedCounter, bus.oYRedCounter} !== {10'd32, 10'd32}) begin
            fails++;
            $display("FAIL timeout_prestrobe: got x=%0d y=%0d need 32 32", bus.oXRedCounter, bus.oYRedCounter);
        end
        strobe();
        tests++;
        if ({bus.oXRedCounter, bus.oYRedCounter, bus.oColorCuadro} !== {10'd0, 10'd0, 3'b001}) begin
            fails++;
            $display("FAIL r_key: got x=%0d y=%0d c=%b need 0 0 001",
                     bus.oXRedCounter, bus.oYRedCounter, bus.oColorCuadro);
        end
    endtask

    task automatic test_parity();
        int p0;
        p0 = perr_cnt;
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h21, 1'b1, 1'b0, 1'b0);
        sb_drain("parity_drop");
        tests++;
        if (perr_cnt - p0 !== 1) begin
            fails++;
            $display("FAIL parity_err_pulses: got %0d need 1", perr_cnt - p0);
        end
        strobe();
        tests++;
        if (bus.oColorCuadro !== 3'b001) begin
            fails++;
            $display("FAIL parity_color: got %b need 001", bus.oColorCuadro);
        end
`else
        send_frame(8'h21, 1'b1, 1'b0, 1'b1);
        sb_drain("parity_ignored");
        strobe();
        tests++;
        if (bus.oColorCuadro !== 3'b010 || perr_cnt !== p0) begin
            fails++;
            $display("FAIL parity_color: got %b need 010", bus.oColorCuadro);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_right();
        test_coincide();
        test_updown();
        test_color();
        test_timeout();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
